// File: rtl/keyboard_matrix_responder.sv
// Emulates an Atari keyboard matrix toward POKEY: host events press/release keys, POKEY scans them.
// Optional macro KBD_EVENT_FIFO_EN replaces the single event holding register with a FIFO_DEPTH-entry FIFO.
module keyboard_matrix_responder #(
  parameter int HOLD_SCANS = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        o2,
  input  logic        rst,
  input  logic [3:0]  key_scan_L,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic [3:0]  ev_code,
  input  logic        ev_mod,
  input  logic        ev_press,
  output logic        kr1_L,
  output logic        kr2_L,
  output logic [15:0] key_state,
  output logic        mod_state
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT_HOLD
  } state_t;

  localparam logic [1:0] LP_HOLD = 2'(HOLD_SCANS);

  state_t     r_state;
  logic       r_curMod;
  logic       r_curPress;
  logic [3:0] r_curCode;
  logic [3:0] r_prevScan;
  logic [1:0] r_scanCnt [16];

  logic [3:0] w_scanCode;
  logic [5:0] w_evIn;
  logic [5:0] w_qHead;
  logic       w_qEmpty;
  logic       w_push;
  logic       w_pop;
  logic       w_pressClr;
  logic       w_holdMet;

  assign w_scanCode = ~key_scan_L;
  assign w_evIn     = {ev_mod, ev_press, ev_code};
  assign w_push     = ev_valid && ev_ready;
  assign w_pop      = (r_state == ST_IDLE) && !w_qEmpty;
  assign w_pressClr = (r_state == ST_APPLY) && !r_curMod && r_curPress && !key_state[r_curCode];
  assign w_holdMet  = (r_scanCnt[r_curCode] >= LP_HOLD);

`ifdef KBD_EVENT_FIFO_EN
  localparam int LP_AW = $clog2(FIFO_DEPTH);

  logic [5:0]       r_fifo [FIFO_DEPTH];
  logic [LP_AW-1:0] r_wrPtr;
  logic [LP_AW-1:0] r_rdPtr;
  logic [LP_AW:0]   r_count;

  assign w_qEmpty = (r_count == '0);
  assign w_qHead  = r_fifo[r_rdPtr];
  assign ev_ready = !rst && (r_count != (LP_AW+1)'(FIFO_DEPTH));

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge o2) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wrPtr] <= w_evIn;
        r_wrPtr         <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count <= r_count + (LP_AW+1)'(w_push) - (LP_AW+1)'(w_pop);
    end
  end
`else
  logic       r_holdValid;
  logic [5:0] r_holdEvt;

  assign w_qEmpty = !r_holdValid;
  assign w_qHead  = r_holdEvt;
  assign ev_ready = !rst && !r_holdValid;

  // Push and pop never coincide: ready is low whenever the register holds an event.
  always_ff @(posedge o2) begin
    if (rst) begin
      r_holdValid <= 1'b0;
    end else if (w_push) begin
      r_holdValid <= 1'b1;
      r_holdEvt   <= w_evIn;
    end else if (w_pop) begin
      r_holdValid <= 1'b0;
    end
  end
`endif

  // A visit is an entry into a scan code; a fresh press restarts that key's count and wins over a same-cycle visit.
  always_ff @(posedge o2) begin
    r_prevScan <= w_scanCode;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_scanCnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_pressClr && (r_curCode == 4'(i))) begin
          r_scanCnt[i] <= 2'd0;
        end else if ((w_scanCode == 4'(i)) && (r_prevScan != 4'(i)) && (r_scanCnt[i] != 2'd3)) begin
          r_scanCnt[i] <= r_scanCnt[i] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge o2) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_curMod   <= 1'b0;
      r_curPress <= 1'b0;
      r_curCode  <= 4'd0;
      key_state  <= 16'd0;
      mod_state  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            {r_curMod, r_curPress, r_curCode} <= w_qHead;
            r_state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          r_state <= ST_IDLE;
          if (r_curMod) begin
            mod_state <= r_curPress;
          end else if (r_curPress) begin
            key_state[r_curCode] <= 1'b1;
          end else if (key_state[r_curCode]) begin
            if (w_holdMet) begin
              key_state[r_curCode] <= 1'b0;
            end else begin
              r_state <= ST_WAIT_HOLD;
            end
          end
        end
        ST_WAIT_HOLD: begin
          if (w_holdMet) begin
            key_state[r_curCode] <= 1'b0;
            r_state              <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Returns see the key map as it stood before this edge, giving one cycle of scan latency.
  always_ff @(posedge o2) begin
    if (rst) begin
      kr1_L <= 1'b1;
      kr2_L <= 1'b1;
    end else begin
      kr1_L <= ~key_state[w_scanCode];
      kr2_L <= ~mod_state;
    end
  end

endmodule

// File: tb/tb_keyboard_matrix_responder.sv
// Self-checking bench for keyboard_matrix_responder: directed scenarios followed by random traffic,
// every cycle compared against an event-queue reference model.
module tb_keyboard_matrix_responder;

  localparam int TB_HOLD = 2;
`ifdef KBD_EVENT_FIFO_EN
  localparam int TB_CAP = 4;
  localparam logic [15:0] EXP_KEYS_037 = 16'h0076;
`else
  localparam int TB_CAP = 1;
  localparam logic [15:0] EXP_KEYS_037 = 16'h0022;
`endif

  logic        o2 = 1'b0;
  logic        rst;
  logic [3:0]  key_scan_L;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        ev_mod;
  logic        ev_press;
  logic        kr1_L;
  logic        kr2_L;
  logic [15:0] key_state;
  logic        mod_state;

  keyboard_matrix_responder #(.HOLD_SCANS(TB_HOLD), .FIFO_DEPTH(4)) dut (
    .o2         (o2),
    .rst        (rst),
    .key_scan_L (key_scan_L),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_mod     (ev_mod),
    .ev_press   (ev_press),
    .kr1_L      (kr1_L),
    .kr2_L      (kr2_L),
    .key_state  (key_state),
    .mod_state  (mod_state)
  );

  always #5 o2 = ~o2;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference model: pending events in a queue, one in-flight event, per-key visit tallies.
  typedef struct packed {
    bit       isMod;
    bit       press;
    bit [3:0] code;
  } evt_t;

  evt_t      mQ[$];
  evt_t      mCur;
  int        mStage = 0;
  bit [15:0] mKeys  = '0;
  bit        mMod   = 1'b0;
  int        mCnt [16];
  int        mPrev  = 0;
  bit        mKr1   = 1'b1;
  bit        mKr2   = 1'b1;
  bit        mValid = 1'b0;
  bit        mLastAcc = 1'b0;

  function automatic bit modelReady();
    return (rst == 1'b0) && (mQ.size() < TB_CAP);
  endfunction

  task automatic modelStep();
    bit [3:0]  s;
    int        scan;
    bit        acc;
    int        oldCnt [16];
    bit [15:0] oldKeys;
    evt_t      inEv;
    s    = ~key_scan_L;
    scan = s;
    acc  = ev_valid && modelReady();
    mLastAcc = acc;
    if (rst) begin
      mQ.delete();
      mStage = 0;
      mKeys  = '0;
      mMod   = 1'b0;
      for (int i = 0; i < 16; i++) mCnt[i] = 0;
      mKr1   = 1'b1;
      mKr2   = 1'b1;
      mPrev  = scan;
      mValid = 1'b1;
      return;
    end
    oldCnt  = mCnt;
    oldKeys = mKeys;
    mKr1 = !oldKeys[scan];
    mKr2 = !mMod;
    if (scan != mPrev && mCnt[scan] < 3) mCnt[scan]++;
    mPrev = scan;
    if (mStage == 0) begin
      if (mQ.size() > 0) begin
        mCur   = mQ.pop_front();
        mStage = 1;
      end
    end else if (mStage == 1) begin
      mStage = 0;
      if (mCur.isMod) mMod = mCur.press;
      else if (mCur.press) begin
        if (!oldKeys[mCur.code]) begin
          mKeys[mCur.code] = 1'b1;
          mCnt[mCur.code]  = 0;
        end
      end else if (oldKeys[mCur.code]) begin
        if (oldCnt[mCur.code] >= TB_HOLD) mKeys[mCur.code] = 1'b0;
        else mStage = 2;
      end
    end else begin
      if (oldCnt[mCur.code] >= TB_HOLD) begin
        mKeys[mCur.code] = 1'b0;
        mStage = 0;
      end
    end
    if (acc) begin
      inEv.isMod = ev_mod;
      inEv.press = ev_press;
      inEv.code  = ev_code;
      mQ.push_back(inEv);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit m, input bit p,
                               input bit [3:0] c, input bit [3:0] scanCode);
    rst = r; ev_valid = v; ev_mod = m; ev_press = p; ev_code = c;
    key_scan_L = ~scanCode;
    #1;
    if (mValid) begin
      checkOutput("ev_ready", ev_ready, modelReady());
      checkOutput("kr1_L", kr1_L, mKr1);
      checkOutput("kr2_L", kr2_L, mKr2);
      checkOutput("key_state", key_state, mKeys);
      checkOutput("mod_state", mod_state, mMod);
    end
    @(posedge o2);
    modelStep();
    #1;
  endtask

  task automatic idleCycles(input int n, input bit [3:0] scanCode);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, scanCode);
  endtask

  task automatic sendEvent(input bit m, input bit p, input bit [3:0] c, input bit [3:0] scanCode);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      applyStimulus(1'b0, 1'b1, m, p, c, scanCode);
      done = mLastAcc;
    end
    if (!done) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int curScan;
    // Reset held for three cycles
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkOutput("rst_kr1", kr1_L, 1'b1);
    checkOutput("rst_kr2", kr2_L, 1'b1);
    checkOutput("rst_keys", key_state, 16'h0000);
    checkOutput("rst_ready", ev_ready, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", ev_ready, 1'b1);

    // Key 5 pressed, then seen by scanning code 5 and lost when scanning 6
    sendEvent(1'b0, 1'b1, 4'd5, 4'd0);
    idleCycles(4, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
    checkOutput("scan5_kr1", kr1_L, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd6);
    checkOutput("scan6_kr1", kr1_L, 1'b1);

    // Quick press/release of key 3 must survive two scan entries
    sendEvent(1'b0, 1'b1, 4'd3, 4'd0);
    sendEvent(1'b0, 1'b0, 4'd3, 4'd0);
    idleCycles(4, 4'd0);
    checkOutput("hold3_before", key_state[3], 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3);
    checkOutput("hold3_second_entry", key_state[3], 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkOutput("hold3_cleared", key_state[3], 1'b0);

    // Modifier press and release
    sendEvent(1'b1, 1'b1, 4'd0, 4'd0);
    idleCycles(3, 4'd0);
    checkOutput("mod_press_kr2", kr2_L, 1'b0);
    checkOutput("mod_keys", key_state, 16'h0020);
    sendEvent(1'b1, 1'b0, 4'd0, 4'd0);
    idleCycles(3, 4'd0);
    checkOutput("mod_release_kr2", kr2_L, 1'b1);

    // Stall on key 9 release while more events pile up
    sendEvent(1'b0, 1'b1, 4'd9, 4'd0);
    idleCycles(3, 4'd0);
    sendEvent(1'b0, 1'b0, 4'd9, 4'd0);
    idleCycles(3, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0);
    rst = 1'b0; ev_valid = 1'b0;
    #1;
    checkOutput("stall_ready_low", ev_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    idleCycles(20, 4'd0);
    checkOutput("stall_drained_keys", key_state, EXP_KEYS_037);

    // Reset while waiting on a release of key 9
    sendEvent(1'b0, 1'b1, 4'd9, 4'd0);
    idleCycles(3, 4'd0);
    sendEvent(1'b0, 1'b0, 4'd9, 4'd0);
    sendEvent(1'b0, 1'b1, 4'd8, 4'd0);
    idleCycles(2, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkOutput("midrst_keys", key_state, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    idleCycles(6, 4'd0);
    checkOutput("midrst_keys_later", key_state, 16'h0000);

    // Random traffic
    curScan = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) curScan = $urandom_range(0, 15);
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 1) == 1),
                    4'($urandom_range(0, 15)),
                    4'(curScan));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/keyboard_matrix_responder.md
KEYBOARD_MATRIX_RESPONDER -- requirements
Module: keyboard_matrix_responder

Interface
REQ-001 Parameter HOLD_SCANS, default 2: scan visits a key must receive after its press before a release is applied (1..3).
REQ-002 Parameter FIFO_DEPTH, default 4: event FIFO depth when KBD_EVENT_FIFO_EN is defined (power of 2, >=2).
REQ-003 o2  in  1  phase-2 clock; the only clock, all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 key_scan_L  in  4  scan lines driven by POKEY; scan code = bitwise inverse of key_scan_L.
REQ-006 ev_valid  in  1  host key event valid.
REQ-007 ev_ready  out  1  responder can accept an event.
REQ-008 ev_code  in  4  key code 0..15 of the event; ignored when ev_mod=1.
REQ-009 ev_mod  in  1  1 = event targets the modifier key (shift/ctrl line).
REQ-010 ev_press  in  1  1 = press, 0 = release.
REQ-011 kr1_L  out  1  key return, low when the currently scanned key is pressed.
REQ-012 kr2_L  out  1  modifier return, low when the modifier is pressed.
REQ-013 key_state  out  16  pressed map, bit n = key n (debug/visibility).
REQ-014 mod_state  out  1  modifier pressed flag.

Function
REQ-015 Event accepted on an o2 edge where ev_valid=1 and ev_ready=1; {ev_mod, ev_press, ev_code} captured in that cycle.
REQ-016 Event processor FSM: IDLE, APPLY, WAIT_HOLD.
REQ-017 IDLE: if an event is queued, pop it and go to APPLY next cycle; else stay.
REQ-018 APPLY, modifier event: mod_state <= ev_press; -> IDLE.
REQ-019 APPLY, key press: set key_state[code], clear scan counter[code] only if the key was not already pressed; -> IDLE.
REQ-020 APPLY, key release of an unpressed key: no change; -> IDLE.
REQ-021 APPLY, key release of a pressed key: if scan counter[code] >= HOLD_SCANS, clear key_state[code] and -> IDLE; else -> WAIT_HOLD.
REQ-022 WAIT_HOLD: clear key_state[code] and -> IDLE in the cycle after the counter reaches HOLD_SCANS; the queue is not popped while in WAIT_HOLD.
REQ-023 Scan counter: 16 x 2-bit, saturating at 3; counter[n] increments in a cycle where scan code = n and the previous cycle's scan code != n (one visit = one entry to n).
REQ-024 kr1_L <= ~key_state[scan code] each cycle (one-cycle latency from key_scan_L).
REQ-025 kr2_L <= ~mod_state each cycle.
REQ-026 When key_state changes in the same cycle that key is scanned, kr1_L reflects the old state that cycle and the new state one cycle later.
REQ-027 A press event for a key that is in WAIT_HOLD cannot occur before the release completes (strict in-order processing).
REQ-028 Throughput: one event per 2 cycles when no hold wait occurs.

Reset
REQ-029 While rst=1: key_state=0, mod_state=0, all scan counters=0, queue empty, FSM=IDLE, kr1_L=1, kr2_L=1, ev_ready=0.
REQ-030 rst asserted mid-event (including in WAIT_HOLD) discards the event and all queued events; ev_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro KBD_EVENT_FIFO_EN defined: events are queued in a FIFO_DEPTH-entry FIFO; ev_ready=0 only when full; a push and a pop in the same cycle when full are not allowed (ready is already 0).
REQ-032 KBD_EVENT_FIFO_EN undefined: single holding register; ev_ready=1 only when the register is empty; the register is freed on pop in IDLE.

Verification
REQ-033 Reset: hold rst 3 cycles -> kr1_L=1, kr2_L=1, key_state=0, ev_ready=0; after release ev_ready=1.
REQ-034 Press key 5 then scan code 5 (key_scan_L=4'b1010) -> kr1_L=0 one cycle after the scan; scan code 6 -> kr1_L=1 one cycle later.
REQ-035 Press key 3 then release immediately, HOLD_SCANS=2 -> key_state[3] stays 1 until two separate entries of scan code 3; cleared the cycle after the second entry.
REQ-036 Modifier press, then release -> kr2_L=0 then 1, one cycle after each APPLY; key_state unchanged.
REQ-037 With KBD_EVENT_FIFO_EN, push 5 events while stalled in WAIT_HOLD -> ev_ready=0 after 4 queued; all events apply in order.
REQ-038 rst pulse during WAIT_HOLD on key 9 -> key_state=0, queue empty, no later release applied.
